// File: rtl/sdhci_dat_pkg.sv
// Shared types and constants for the SD DAT-line write path.
//  - tx_state_e : transmitter state encoding
//  - CRC16_POLY : CCITT polynomial used on every DAT lane
//  - STATUS_*   : CRC status token values reported on crc_status_o
//  - crc16_step : one bit-serial CRC16 update
package sdhci_dat_pkg;

    typedef enum logic [3:0] {
        TX_IDLE      = 4'd0,
        TX_START     = 4'd1,
        TX_DATA      = 4'd2,
        TX_CRC       = 4'd3,
        TX_END       = 4'd4,
        TX_RELEASE   = 4'd5,
        TX_STAT_WAIT = 4'd6,
        TX_STAT      = 4'd7,
        TX_BUSY      = 4'd8,
        TX_DONE      = 4'd9
    } tx_state_e;

    localparam logic [15:0] CRC16_POLY     = 16'h1021;

    localparam logic [2:0]  STATUS_OK      = 3'b010;
    localparam logic [2:0]  STATUS_CRC_ERR = 3'b101;
    localparam logic [2:0]  STATUS_WR_ERR  = 3'b110;
    localparam logic [2:0]  STATUS_TIMEOUT = 3'b111;

    // Shift one message bit into a CRC16 register (MSB-first, no reflection).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CCITT CRC16 for one DAT lane, initial value 0.
//  clk_i  in  system clock
//  rst_i  in  asynchronous reset, active-high
//  en_i   in  shift bit_i into the CRC this cycle
//  clr_i  in  clear the CRC to 0 (has priority over en_i)
//  bit_i  in  message bit
//  crc_o  out current CRC value
module sd_crc16
    import sdhci_dat_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    // CRC register: cleared at block start, advanced once per data bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 16'h0000;
        end else if (clr_i) begin
            crc_q <= 16'h0000;
        end else if (en_i) begin
            crc_q <= crc16_step(crc_q, bit_i);
        end else begin
            crc_q <= crc_q;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/dat_tx_serializer.sv
// SD write-path DAT transmitter. Pops 32-bit words from the data buffer and
// sends one block as start bit, data, per-lane CRC16 and end bit on 1 or 4
// DAT lanes, then collects the card's CRC status token and waits out busy.
//  clk_i/rst_i        clock, asynchronous active-high reset
//  start_i            request one block (accepted only in IDLE)
//  bus_width_4_i      4-bit mode select, sampled at start
//  block_size_i       block length in bytes, sampled at start
//  read_valid_i       buffer holds a full block
//  read_data_i        buffer front word (byte 0 in [7:0])
//  read_ready_o       pop strobe, one cycle per word
//  sd_clk_en_i        one strobe per SD bit period
//  dat_i/dat_o/dat_oe_o  DAT lines in, out, output enable
//  busy_o/done_o      activity flag / end-of-block pulse
//  crc_status_o       last status token (111 on timeout)
module dat_tx_serializer
    import sdhci_dat_pkg::*;
#(
    parameter int MaxBlockBitSize = 12,
    parameter int StatusTimeout   = 16,
    parameter int BusyTimeoutW    = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       bus_width_4_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic                       read_valid_i,
    input  logic [31:0]                read_data_i,
    output logic                       read_ready_o,
    input  logic                       sd_clk_en_i,
    input  logic [3:0]                 dat_i,
    output logic [3:0]                 dat_o,
    output logic                       dat_oe_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [2:0]                 crc_status_o
);

    tx_state_e                   state_q, state_d;
    logic                        width4_q, width4_d;
    logic [MaxBlockBitSize-1:0]  size_q, size_d;
    logic [MaxBlockBitSize-1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]                  bit_cnt_q, bit_cnt_d;
    logic [3:0]                  crc_cnt_q, crc_cnt_d;
    logic [BusyTimeoutW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]                 word_q, word_d;
    logic [3:0]                  dat_q, dat_d;
    logic                        oe_q, oe_d;
    logic                        busy_q;
    logic                        done_q, done_d;
    logic [2:0]                  status_q, status_d;

    logic [7:0]                  cur_byte_s;
    logic [3:0]                  data_lanes_s;
    logic [3:0]                  crc_idx_s;
    logic [3:0]                  lane_crc_s;
    logic [3:0]                  crc_bits_s;
    logic [3:0][15:0]            crc_s;
    logic                        byte_end_s;
    logic                        last_byte_s;
    logic                        crc_en_s;
    logic                        crc_clr_s;
    logic                        pop_s;
    logic                        dat_unused_s;

    // Status and busy are only ever signalled on DAT0.
    assign dat_unused_s = ^dat_i[3:1];

    assign cur_byte_s  = word_q[{byte_cnt_q[1:0], 3'b000} +: 8];
    assign byte_end_s  = width4_q ? (bit_cnt_q == 3'd4) : (bit_cnt_q == 3'd7);
    assign last_byte_s = (byte_cnt_q == (size_q - MaxBlockBitSize'(1)));
    assign crc_idx_s   = 4'd15 - crc_cnt_q;

    // Lane values for the current data bit; bit_cnt steps by 4 in 4-bit mode.
    always_comb begin
        data_lanes_s = 4'hF;
        if (width4_q) begin
            data_lanes_s = bit_cnt_q[2] ? cur_byte_s[3:0] : cur_byte_s[7:4];
        end else begin
            data_lanes_s = {3'b111, cur_byte_s[3'd7 - bit_cnt_q]};
        end
    end

    // Lane values for the current CRC bit, MSB first on each lane.
    always_comb begin
        lane_crc_s = 4'h0;
        for (int l = 0; l < 4; l++) begin
            lane_crc_s[l] = crc_s[l][crc_idx_s];
        end
        if (width4_q) begin
            crc_bits_s = lane_crc_s;
        end else begin
            crc_bits_s = {3'b111, lane_crc_s[0]};
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane_crc
        sd_crc16 u_crc (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (crc_en_s),
            .clr_i (crc_clr_s),
            .bit_i (data_lanes_s[g]),
            .crc_o (crc_s[g])
        );
    end

    // Next-state, counters and output values; strobe-gated except IDLE and DONE.
    always_comb begin
        state_d    = state_q;
        width4_d   = width4_q;
        size_d     = size_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
        dat_d      = dat_q;
        oe_d       = oe_q;
        done_d     = 1'b0;
        status_d   = status_q;
        pop_s      = 1'b0;
        crc_en_s   = 1'b0;
        crc_clr_s  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (start_i && read_valid_i && (block_size_i != '0)) begin
                    width4_d = bus_width_4_i;
                    size_d   = block_size_i;
                    state_d  = TX_START;
                end else begin
                    state_d  = TX_IDLE;
                end
            end
            TX_START: begin
                if (sd_clk_en_i) begin
                    dat_d      = width4_q ? 4'h0 : 4'hE;
                    oe_d       = 1'b1;
                    pop_s      = 1'b1;
                    word_d     = read_data_i;
                    byte_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    crc_cnt_d  = 4'd0;
                    wait_cnt_d = '0;
                    crc_clr_s  = 1'b1;
                    state_d    = TX_DATA;
                end else begin
                    state_d    = TX_START;
                end
            end
            TX_DATA: begin
                if (sd_clk_en_i) begin
                    dat_d    = data_lanes_s;
                    crc_en_s = 1'b1;
                    if (byte_end_s) begin
                        bit_cnt_d = 3'd0;
                        if (last_byte_s) begin
                            state_d = TX_CRC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + MaxBlockBitSize'(1);
                            // Last bit of a full word with bytes left: fetch the next word now.
                            if (byte_cnt_q[1:0] == 2'b11) begin
                                pop_s  = 1'b1;
                                word_d = read_data_i;
                            end else begin
                                word_d = word_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + (width4_q ? 3'd4 : 3'd1);
                    end
                end else begin
                    state_d = TX_DATA;
                end
            end
            TX_CRC: begin
                if (sd_clk_en_i) begin
                    dat_d     = crc_bits_s;
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'd15) begin
                        state_d = TX_END;
                    end else begin
                        state_d = TX_CRC;
                    end
                end else begin
                    state_d = TX_CRC;
                end
            end
            TX_END: begin
                if (sd_clk_en_i) begin
                    dat_d   = 4'hF;
                    state_d = TX_RELEASE;
                end else begin
                    state_d = TX_END;
                end
            end
            TX_RELEASE: begin
                if (sd_clk_en_i) begin
                    oe_d       = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = TX_STAT_WAIT;
                end else begin
                    state_d    = TX_RELEASE;
                end
            end
            TX_STAT_WAIT: begin
                if (sd_clk_en_i) begin
                    if (!dat_i[0]) begin
                        bit_cnt_d = 3'd0;
                        state_d   = TX_STAT;
                    end else if (wait_cnt_q == BusyTimeoutW'(StatusTimeout - 1)) begin
                        status_d  = STATUS_TIMEOUT;
                        state_d   = TX_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + BusyTimeoutW'(1);
                    end
                end else begin
                    state_d = TX_STAT_WAIT;
                end
            end
            TX_STAT: begin
                if (sd_clk_en_i) begin
                    // Three token bits, then one strobe to skip the token end bit.
                    if (bit_cnt_q == 3'd3) begin
                        wait_cnt_d = '0;
                        state_d    = TX_BUSY;
                    end else begin
                        status_d  = {status_q[1:0], dat_i[0]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = TX_STAT;
                end
            end
            TX_BUSY: begin
                if (sd_clk_en_i) begin
                    if (dat_i[0]) begin
                        state_d = TX_DONE;
                    end else if (&wait_cnt_q) begin
                        status_d = STATUS_TIMEOUT;
                        state_d  = TX_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + BusyTimeoutW'(1);
                    end
                end else begin
                    state_d = TX_BUSY;
                end
            end
            TX_DONE: begin
                done_d  = 1'b1;
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TX_IDLE;
            width4_q   <= 1'b0;
            size_q     <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            crc_cnt_q  <= 4'd0;
            wait_cnt_q <= '0;
            word_q     <= 32'h0000_0000;
            dat_q      <= 4'hF;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            width4_q   <= width4_d;
            size_q     <= size_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            dat_q      <= dat_d;
            oe_q       <= oe_d;
            busy_q     <= (state_d != TX_IDLE);
            done_q     <= done_d;
            status_q   <= status_d;
        end
    end

    // The pop must coincide with the cycle the word is captured, so it is not registered.
    assign read_ready_o = pop_s;
    assign dat_o        = dat_q;
    assign dat_oe_o     = oe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign crc_status_o = status_q;

endmodule
